// File: rtl/accumulator_unit_if.sv
// Instruction/register-file bundle between a sequencer and accumulator_unit.
// The master side drives instructions and returns register-file read data.
interface accumulator_unit_if;
  logic       start;
  logic [2:0] opcode;
  logic [3:0] reg_index;
  logic [7:0] immediate;
  logic [7:0] rf_read_data;
  logic [3:0] rf_read_address;
  logic       rf_write_enable;
  logic [3:0] rf_write_address;
  logic [7:0] rf_write_data;
  logic [7:0] acc;
  logic       carry;
  logic       zero;
  logic       busy;
  logic       done;

  modport master (
    output start, opcode, reg_index, immediate, rf_read_data,
    input  rf_read_address, rf_write_enable, rf_write_address, rf_write_data,
    input  acc, carry, zero, busy, done
  );

  modport slave (
    input  start, opcode, reg_index, immediate, rf_read_data,
    output rf_read_address, rf_write_enable, rf_write_address, rf_write_data,
    output acc, carry, zero, busy, done
  );
endinterface

// File: rtl/accumulator_unit.sv
// Multi-cycle 8-bit accumulator unit executing one instruction at a time
// against an external register file (IDLE/READ/EXEC/WRITE/DONE sequencer).
module accumulator_unit (
  input  logic              clk,
  input  logic              rst_n,
  accumulator_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_EXEC, S_WRITE, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000, OP_LDI = 3'b001, OP_LDR = 3'b010, OP_STR = 3'b011,
    OP_ADD = 3'b100, OP_SUB = 3'b101, OP_AND = 3'b110, OP_XOR = 3'b111
  } op_t;

  state_t     state_q;
  op_t        opcode_q;
  logic [3:0] idx_q;
  logic [7:0] imm_q;
  logic [7:0] operand_q;
  logic [7:0] acc_q;
  logic       carry_q;
  logic       zero_q;
  logic       busy_q;
  logic       done_q;

  logic [8:0] sum;
  logic [7:0] acc_d;
  logic       carry_d;
  logic       zero_d;
  op_t        op_in;

  assign op_in = op_t'(bus.opcode);

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, operand_q};
    acc_d   = acc_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    case (opcode_q)
      OP_LDI: acc_d = imm_q;
      OP_LDR: acc_d = operand_q;
      OP_ADD: {carry_d, acc_d} = sum;
      OP_SUB: begin
        acc_d   = acc_q - operand_q;
        carry_d = (acc_q < operand_q);
      end
      OP_AND: acc_d = acc_q & operand_q;
      OP_XOR: acc_d = acc_q ^ operand_q;
      default: ;
    endcase
    if (opcode_q != OP_NOP && opcode_q != OP_STR)
      zero_d = (acc_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      opcode_q  <= OP_NOP;
      idx_q     <= '0;
      imm_q     <= '0;
      operand_q <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            opcode_q <= op_in;
            idx_q    <= bus.reg_index;
            imm_q    <= bus.immediate;
            busy_q   <= 1'b1;
            case (op_in)
              OP_NOP, OP_LDI: state_q <= S_EXEC;
              OP_STR:         state_q <= S_WRITE;
              default:        state_q <= S_READ;
            endcase
          end
        end
        S_READ: begin
          operand_q <= bus.rf_read_data;
          state_q   <= S_EXEC;
        end
        S_EXEC: begin
          acc_q   <= acc_d;
          carry_q <= carry_d;
          zero_q  <= zero_d;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_WRITE: begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Write strobe is gated by rst_n so a reset edge can never commit a write.
  assign bus.rf_write_enable  = (state_q == S_WRITE) && rst_n;
  assign bus.rf_read_address  = idx_q;
  assign bus.rf_write_address = idx_q;
  assign bus.rf_write_data    = acc_q;
  assign bus.acc              = acc_q;
  assign bus.carry            = carry_q;
  assign bus.zero             = zero_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;

endmodule

// File: tb/tb_accumulator_unit.sv
// Self-checking bench for accumulator_unit: vector table with a scoreboard
// of expected results, plus hand-written reset and busy-start sequences.
module tb_accumulator_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  accumulator_unit_if bus ();

  accumulator_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] op;
    logic [3:0] idx;
    logic [7:0] imm;
    bit         pre;
    logic [7:0] pval;
    logic [7:0] acc;
    bit         c;
    bit         z;
  } vec_t;

  typedef struct {
    logic [7:0]  acc;
    bit          c;
    bit          z;
    int unsigned lat;
  } exp_t;

  int tests = 0;
  int fails = 0;

  exp_t sb[$];

  // Register-file model and event counters
  logic [7:0] rf [16] = '{default: 8'h00};
  logic       pre_req = 1'b0;
  logic [3:0] pre_idx = '0;
  logic [7:0] pre_val = '0;
  int unsigned wr_cnt   = 0;
  int unsigned done_cnt = 0;
  logic [3:0]  wr_addr_last = '0;
  logic [7:0]  wr_data_last = '0;

  assign bus.rf_read_data = rf[bus.rf_read_address];

  always @(posedge clk) begin
    if (bus.rf_write_enable) begin
      rf[bus.rf_write_address] <= bus.rf_write_data;
      wr_cnt       <= wr_cnt + 1;
      wr_addr_last <= bus.rf_write_address;
      wr_data_last <= bus.rf_write_data;
    end
    if (pre_req) rf[pre_idx] <= pre_val;
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned lat_of(input logic [2:0] op);
    return (op == 3'b000 || op == 3'b001 || op == 3'b011) ? 2 : 3;
  endfunction

  task automatic preset(input logic [3:0] i, input logic [7:0] v);
    @(negedge clk);
    pre_idx = i;
    pre_val = v;
    pre_req = 1'b1;
    @(negedge clk);
    pre_req = 1'b0;
  endtask

  // Issue one instruction; with hold set, start stays asserted (with a
  // different opcode) until the done cycle to show busy-time starts are ignored.
  task automatic do_instr(input logic [2:0] op, input logic [3:0] idx,
                          input logic [7:0] imm, input exp_t e, input bit hold);
    int unsigned n;
    int unsigned d0;
    exp_t got;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.opcode    = op;
    bus.reg_index = idx;
    bus.immediate = imm;
    sb.push_back(e);
    d0 = done_cnt;
    @(posedge clk);
    @(negedge clk);
    n = 1;
    check("busy_cycle1", {31'b0, bus.busy}, 32'd1);
    if (hold) begin
      bus.opcode    = 3'b001;
      bus.immediate = 8'h77;
    end else begin
      bus.start = 1'b0;
    end
    while (!bus.done && n < 8) begin
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    got = sb.pop_front();
    if (!bus.done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles expected %0d", n, got.lat);
    end else begin
      check("latency", n, got.lat);
      check("acc", {24'b0, bus.acc}, {24'b0, got.acc});
      check("carry", {31'b0, bus.carry}, {31'b0, got.c});
      check("zero", {31'b0, bus.zero}, {31'b0, got.z});
    end
    @(negedge clk);
    check("done_one_cycle", {31'b0, bus.done}, 32'd0);
    check("busy_after", {31'b0, bus.busy}, 32'd0);
    if (hold) begin
      repeat (3) @(negedge clk);
      check("busy_stays_idle", {31'b0, bus.busy}, 32'd0);
    end
    check("done_count", done_cnt - d0, 32'd1);
  endtask

  vec_t vt[18];

  initial begin
    exp_t e;
    int unsigned w0;
    int unsigned d0;

    vt[0]  = '{3'b001, 4'd0,  8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1}; // LDI 00
    vt[1]  = '{3'b001, 4'd0,  8'hF0, 1'b0, 8'h00, 8'hF0, 1'b0, 1'b0}; // LDI F0
    vt[2]  = '{3'b100, 4'd3,  8'h00, 1'b1, 8'h20, 8'h10, 1'b1, 1'b0}; // ADD r3=20
    vt[3]  = '{3'b001, 4'd0,  8'h05, 1'b0, 8'h00, 8'h05, 1'b1, 1'b0}; // LDI keeps carry
    vt[4]  = '{3'b101, 4'd7,  8'h00, 1'b1, 8'h06, 8'hFF, 1'b1, 1'b0}; // SUB borrow
    vt[5]  = '{3'b001, 4'd0,  8'h05, 1'b0, 8'h00, 8'h05, 1'b1, 1'b0};
    vt[6]  = '{3'b101, 4'd7,  8'h00, 1'b1, 8'h05, 8'h00, 1'b0, 1'b1}; // SUB to zero
    vt[7]  = '{3'b000, 4'd9,  8'hAA, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1}; // NOP
    vt[8]  = '{3'b001, 4'd0,  8'hA5, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0};
    vt[9]  = '{3'b011, 4'd15, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0}; // STR r15
    vt[10] = '{3'b001, 4'd0,  8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    vt[11] = '{3'b010, 4'd15, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0}; // LDR r15
    vt[12] = '{3'b110, 4'd4,  8'h00, 1'b1, 8'h0F, 8'h05, 1'b0, 1'b0}; // AND
    vt[13] = '{3'b111, 4'd5,  8'h00, 1'b1, 8'h05, 8'h00, 1'b0, 1'b1}; // XOR
    vt[14] = '{3'b100, 4'd6,  8'h00, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0};
    vt[15] = '{3'b100, 4'd1,  8'h00, 1'b1, 8'h01, 8'h00, 1'b1, 1'b1}; // wrap to 0
    vt[16] = '{3'b000, 4'd0,  8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1};
    vt[17] = '{3'b101, 4'd0,  8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1}; // 0-0

    rst_n         = 1'b0;
    bus.start     = 1'b1;
    bus.opcode    = 3'b001;
    bus.reg_index = 4'd0;
    bus.immediate = 8'h55;
    repeat (3) @(negedge clk);
    check("rst_acc", {24'b0, bus.acc}, 32'h0);
    check("rst_carry", {31'b0, bus.carry}, 32'd0);
    check("rst_zero", {31'b0, bus.zero}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_we", {31'b0, bus.rf_write_enable}, 32'd0);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("start_in_reset_ignored", {31'b0, bus.busy}, 32'd0);
    check("start_in_reset_acc", {24'b0, bus.acc}, 32'h0);

    for (int i = 0; i < 18; i++) begin
      if (vt[i].pre) preset(vt[i].idx, vt[i].pval);
      e.acc = vt[i].acc;
      e.c   = vt[i].c;
      e.z   = vt[i].z;
      e.lat = lat_of(vt[i].op);
      w0 = wr_cnt;
      do_instr(vt[i].op, vt[i].idx, vt[i].imm, e, 1'b0);
      if (vt[i].op == 3'b011) begin
        check("str_write_pulses", wr_cnt - w0, 32'd1);
        check("str_addr", {28'b0, wr_addr_last}, {28'b0, vt[i].idx});
        check("str_data", {24'b0, wr_data_last}, {24'b0, vt[i].acc});
        check("str_rf", {24'b0, rf[vt[i].idx]}, {24'b0, vt[i].acc});
      end else begin
        check("no_write", wr_cnt - w0, 32'd0);
      end
    end

    // ADD with start held high throughout: only the ADD executes
    preset(4'd2, 8'h33);
    e = '{8'h33, 1'b0, 1'b0, 3};
    do_instr(3'b100, 4'd2, 8'h00, e, 1'b1);
    check("hold_acc_kept", {24'b0, bus.acc}, 32'h33);

    // Reset during the WRITE cycle of STR r2
    preset(4'd2, 8'h5A);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.opcode    = 3'b011;
    bus.reg_index = 4'd2;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    w0 = wr_cnt;
    d0 = done_cnt;
    check("str_busy", {31'b0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("we_gated_by_reset", {31'b0, bus.rf_write_enable}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_write", wr_cnt - w0, 32'd0);
    check("abort_rf2", {24'b0, rf[2]}, 32'h5A);
    check("abort_no_done", done_cnt - d0, 32'd0);
    check("abort_acc", {24'b0, bus.acc}, 32'h0);
    check("abort_carry", {31'b0, bus.carry}, 32'd0);
    check("abort_zero", {31'b0, bus.zero}, 32'd0);
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/accumulator_unit.md
ACCUMULATOR_UNIT -- requirements
Module: accumulator_unit

Interface
REQ-001 SHALL have one clock and one reset: synchronous, active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 start  input  1  instruction valid; sampled only in IDLE.
REQ-005 opcode  input  3  operation: 000 NOP, 001 LDI, 010 LDR, 011 STR, 100 ADD, 101 SUB, 110 AND, 111 XOR.
REQ-006 reg_index  input  4  register-file index for LDR/STR/ALU ops.
REQ-007 immediate  input  8  immediate operand for LDI.
REQ-008 rf_read_data  input  8  combinational read data returned by the register file.
REQ-009 rf_read_address  output  4  register-file read index.
REQ-010 rf_write_enable  output  1  register-file write strobe.
REQ-011 rf_write_address  output  4  register-file write index.
REQ-012 rf_write_data  output  8  register-file write data.
REQ-013 acc  output  8  accumulator value.
REQ-014 carry  output  1  carry (ADD) / borrow (SUB) flag.
REQ-015 zero  output  1  result-equals-zero flag.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, READ, EXEC, WRITE, DONE.
REQ-019 IDLE, start=1: latch opcode, reg_index, immediate; go to READ for LDR/ADD/SUB/AND/XOR, EXEC for NOP/LDI, WRITE for STR.
REQ-020 IDLE, start=0: stay in IDLE.
REQ-021 start while busy=1 (READ/EXEC/WRITE/DONE) SHALL be ignored, no queuing.
REQ-022 READ: capture rf_read_data into operand register; go to EXEC.
REQ-023 EXEC: update acc/flags per opcode; go to DONE.
REQ-024 WRITE: rf_write_enable=1 for exactly this one cycle; go to DONE.
REQ-025 DONE: done=1 for exactly one cycle; go to IDLE.
REQ-026 rf_read_address and rf_write_address SHALL equal latched reg_index; rf_write_data SHALL equal acc.
REQ-027 rf_write_enable SHALL be (state==WRITE) AND rst_n, combinationally, so no register write occurs on a reset edge.
REQ-028 LDI: acc<=immediate; LDR: acc<=operand; AND/XOR: acc<=acc op operand; carry unchanged for all four.
REQ-029 ADD: {carry,acc}<=acc+operand, 9-bit sum, wraps modulo 256.
REQ-030 SUB: acc<=(acc-operand) mod 256; carry<=1 iff acc<operand (unsigned).
REQ-031 zero SHALL update to (new acc==0) on LDI/LDR/ADD/SUB/AND/XOR.
REQ-032 NOP and STR SHALL leave acc, carry, zero unchanged.
REQ-033 Latency from start-sampling edge: NOP/LDI done in cycle 2; STR done in cycle 2 (write at end of cycle 1); LDR/ALU done in cycle 3; next start accepted in the cycle after done.
REQ-034 acc update SHALL be visible in the same cycle done is high.
REQ-035 Reading and writing the same index is legal; STR writes the current acc.

Reset
REQ-036 rst_n=0 at a rising edge SHALL force: state IDLE, acc=0x00, carry=0, zero=0, latched opcode/index/immediate/operand=0, busy=0, done=0.
REQ-037 Reset mid-operation SHALL abort the instruction with no acc/flag update and no done pulse.
REQ-038 start sampled in the same cycle as rst_n=0 SHALL be ignored.

Verification
REQ-039 Reset, then LDI imm=0x00 -> acc=0x00, zero=1, done in cycle 2, busy high cycles 1-2.
REQ-040 LDI 0xF0; register 3 preset 0x20; ADD idx 3 -> acc=0x10, carry=1, zero=0, done in cycle 3.
REQ-041 acc=0x05, register 7=0x06, SUB idx 7 -> acc=0xFF, carry=1; then register 7=0x05, SUB idx 7 with acc=0x05 -> acc=0x00, carry=0, zero=1.
REQ-042 LDI 0xA5, STR idx 15 -> rf_write_enable high one cycle, address 0xF, data 0xA5; LDR idx 15 after clearing acc -> acc=0xA5.
REQ-043 start pulsed every cycle during an ADD -> only first instruction executes; exactly one done pulse.
REQ-044 rst_n=0 during WRITE of STR idx 2 -> rf_write_enable=0 that cycle, register 2 unchanged, no done, acc=0x00 afterwards.
